// File: rtl/morse_encoder.sv
// morse_encoder
//
// Serial Morse generator for the letters S..Z. One letter is sent per start
// request, one pattern bit per symbol tick, MSB first. A dot is "10" and a
// dash is "1110"; the trailing 0 of each symbol forms the gap.
//
// Ports:
//   clock       system clock, rising edge
//   reset       synchronous, active-high reset (priority over start/tick)
//   tick        one-cycle symbol-timing enable from the rate divider
//   start       request to send a letter, level-sampled while idle
//   letter_sel  0=S 1=T 2=U 3=V 4=W 5=X 6=Y 7=Z, sampled on IDLE->ARM
//   led         Morse output, 1 = tone on
//   busy        high while a letter is armed or running
//   done        one-cycle pulse in the first idle cycle after a letter
//   remaining   symbols left including the current one, 0 outside RUN
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; outputs quiet
// ARM   | letter latched, waiting for a tick so bit 0 gets a full interval
// RUN   | shifting the pattern out, one bit per tick

module morse_encoder #(
    parameter int PAT_W = 14,
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             tick,
    input  logic             start,
    input  logic [2:0]       letter_sel,
    output logic             led,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] remaining
);

    localparam int CODE_W = 14;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;

    // Patterns are stored in a fixed 14-bit field, then left-aligned into
    // the shift register so wider PAT_W values just add trailing zeros.
    function automatic logic [PAT_W-1:0] rom_pat(input logic [2:0] sel);
        logic [CODE_W-1:0] code;
        logic [PAT_W-1:0]  full;
        case (sel)
            3'd0:    code = 14'b10101000000000;   // S
            3'd1:    code = 14'b11100000000000;   // T
            3'd2:    code = 14'b10101110000000;   // U
            3'd3:    code = 14'b10101011100000;   // V
            3'd4:    code = 14'b10111011100000;   // W
            3'd5:    code = 14'b11101010111000;   // X
            3'd6:    code = 14'b11101011101110;   // Y
            default: code = 14'b11101110101000;   // Z
        endcase
        full = '0;
        full[PAT_W-1 -: CODE_W] = code;
        return full;
    endfunction

    function automatic logic [CNT_W-1:0] rom_len(input logic [2:0] sel);
        logic [CNT_W-1:0] len;
        case (sel)
            3'd0:    len = CNT_W'(6);
            3'd1:    len = CNT_W'(4);
            3'd2:    len = CNT_W'(8);
            3'd3:    len = CNT_W'(10);
            3'd4:    len = CNT_W'(10);
            3'd5:    len = CNT_W'(12);
            3'd6:    len = CNT_W'(14);
            default: len = CNT_W'(12);
        endcase
        return len;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            pat_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // A tick in the same cycle is deliberately not consumed:
                // ARM always waits for a fresh tick.
                if (start) begin
                    pat_d   = rom_pat(letter_sel);
                    cnt_d   = rom_len(letter_sel);
                    state_d = ARM;
                end
            end
            ARM: begin
                if (tick) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (tick) begin
                    if (cnt_q > CNT_W'(1)) begin
                        pat_d = {pat_q[PAT_W-2:0], 1'b0};
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        pat_d   = '0;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                pat_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    assign led       = (state_q == RUN) & pat_q[PAT_W-1];
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign remaining = (state_q == RUN) ? cnt_q : '0;

endmodule
